// File: rtl/lut_mult_pkg.sv
// Shared encodings and helpers for the sequential 2-bit LUT multiplier.
// The LUT_MULT_EARLY_EXIT_EN build option is consumed by lut_mult_seq_ctrl.
package lut_mult_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  typedef enum logic [1:0] {
    StIdle = ST_IDLE,
    StRun  = ST_RUN,
    StDone = ST_DONE
  } state_e;

  localparam logic [1:0] SEL_0 = 2'd0;
  localparam logic [1:0] SEL_1 = 2'd1;
  localparam logic [1:0] SEL_2 = 2'd2;
  localparam logic [1:0] SEL_3 = 2'd3;

  // Smallest r with 2**r >= value; 0 for value <= 1.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(value)) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/lut_pp_2b.sv
// Combinational 2-bit partial-product LUT: returns {0, A, 2A, 3A} selected by sel.
// Output is forced to zero while reset is asserted (active-low).
module lut_pp_2b
  import lut_mult_pkg::*;
#(
  parameter int unsigned N = 4
) (
  input  logic         reset,
  input  logic [N-1:0] A,
  input  logic [1:0]   sel,
  output logic [N+1:0] pp
);

  logic [N+1:0] a_x1;
  logic [N+1:0] a_x2;

  assign a_x1 = {2'b00, A};
  assign a_x2 = {1'b0, A, 1'b0};

  always_comb begin
    pp = '0;
    if (reset) begin
      unique case (sel)
        SEL_0:   pp = '0;
        SEL_1:   pp = a_x1;
        SEL_2:   pp = a_x2;
        SEL_3:   pp = a_x1 + a_x2;
        default: pp = '0;
      endcase
    end
  end

endmodule

// File: rtl/lut_mult_seq_ctrl.sv
// Sequential A*B multiplier: consumes B two bits per cycle through one LUT stage.
// Define LUT_MULT_EARLY_EXIT_EN to finish as soon as the remaining B bits are all zero.
module lut_mult_seq_ctrl
  import lut_mult_pkg::*;
#(
  parameter int unsigned N = 4,
  parameter int unsigned M = 8
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           start,
  input  logic [N-1:0]   A,
  input  logic [M-1:0]   B,
  output logic           ready,
  output logic           busy,
  output logic           done,
  output logic [N+M-1:0] AB
);

  localparam int unsigned Steps = M / 2;
  localparam int unsigned CntW  = (clog2(Steps) > 0) ? clog2(Steps) : 1;
  localparam int unsigned W     = N + M;
  localparam logic [CntW-1:0] LastCnt = CntW'(Steps - 1);

  state_e        state_q;
  logic [CntW-1:0] cnt_q;
  logic [N-1:0]  a_q;
  logic [M-1:0]  b_q;
  logic [W-1:0]  acc_q;

  logic [N+1:0]  pp;
  logic [W-1:0]  acc_next;
  logic [M-1:0]  b_next;
  logic          last_step;

  lut_pp_2b #(
    .N(N)
  ) u_pp (
    .reset(reset),
    .A    (a_q),
    .sel  (b_q[1:0]),
    .pp   (pp)
  );

  always_comb begin
    acc_next  = acc_q + (W'(pp) << {cnt_q, 1'b0});
    b_next    = b_q >> 2;
    last_step = (cnt_q == LastCnt);
`ifdef LUT_MULT_EARLY_EXIT_EN
    // No set bits left in B: further steps would only add zero.
    if (b_next == '0) last_step = 1'b1;
`endif
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      AB      <= '0;
      done    <= 1'b0;
      busy    <= 1'b0;
      ready   <= 1'b1;
    end else begin
      unique case (state_q)
        StIdle: begin
          done <= 1'b0;
          if (start) begin
            acc_q   <= '0;
            cnt_q   <= '0;
            a_q     <= A;
            b_q     <= B;
            state_q <= StRun;
            ready   <= 1'b0;
            busy    <= 1'b1;
          end
        end
        StRun: begin
          acc_q <= acc_next;
          b_q   <= b_next;
          if (last_step) begin
            AB      <= acc_next;
            done    <= 1'b1;
            state_q <= StDone;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        StDone: begin
          done    <= 1'b0;
          busy    <= 1'b0;
          ready   <= 1'b1;
          state_q <= StIdle;
        end
        default: begin
          done    <= 1'b0;
          busy    <= 1'b0;
          ready   <= 1'b1;
          state_q <= StIdle;
        end
      endcase
    end
  end

endmodule
